// File: rtl/isp_pkg.sv
// rtl/isp_pkg.sv - shared types, Bayer codes and helpers for the raw test-pattern source
package isp_pkg;

    // Frame-timing FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } tpg_state_t;

    // Bayer colour code of a pixel after applying the CFA order
    localparam logic [1:0] FMT_R  = 2'd0;
    localparam logic [1:0] FMT_GR = 2'd1;
    localparam logic [1:0] FMT_GB = 2'd2;
    localparam logic [1:0] FMT_B  = 2'd3;

    // Base pattern selections
    localparam logic [1:0] PAT_FLAT  = 2'd0;
    localparam logic [1:0] PAT_BAYER = 2'd1;
    localparam logic [1:0] PAT_HRAMP = 2'd2;
    localparam logic [1:0] PAT_VRAMP = 2'd3;

    // Bits needed to count 0..n-1; never less than one so vectors stay legal
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/isp_tpg_timing.sv
// rtl/isp_tpg_timing.sv - frame FSM, pixel/line counters and raw sync strobes
module isp_tpg_timing
    import isp_pkg::*;
#(
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 960,
    parameter int HBLANK      = 160,
    parameter int VSYNC_LINES = 2,
    parameter int VBP_LINES   = 8,
    parameter int VFP_LINES   = 8,
    parameter int HW          = clog2(WIDTH + HBLANK),
    parameter int VW          = clog2(HEIGHT)
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          i_enable,
    output logic [HW-1:0] o_h,
    output logic [VW-1:0] o_v,
    output logic          o_href,
    output logic          o_vsync,
    output logic          o_frame_done,
    output logic          o_cfg_load
);

    localparam int LINE_LEN = WIDTH + HBLANK;

    tpg_state_t    r_state;
    tpg_state_t    w_state_nxt;
    logic [HW-1:0] r_h;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] r_v;
    logic [VW-1:0] w_v_nxt;
    logic [VW-1:0] w_lines_m1;
    logic          w_line_end;
    logic          w_last_line;
    logic          w_cfg_load;

    // State and counter registers; v counts lines within the current region
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
        end
    end

    // Length of the current region in lines, minus one
    always_comb begin
        w_lines_m1 = '0;
        case (r_state)
            ST_VSYNC:  w_lines_m1 = VW'(VSYNC_LINES - 1);
            ST_VBP:    w_lines_m1 = VW'(VBP_LINES - 1);
            ST_ACTIVE: w_lines_m1 = VW'(HEIGHT - 1);
            ST_VFP:    w_lines_m1 = VW'(VFP_LINES - 1);
            default:   w_lines_m1 = '0;
        endcase
    end

    assign w_line_end  = (r_h == HW'(LINE_LEN - 1));
    assign w_last_line = (r_v == w_lines_m1);

    // Next state and counters; enable only matters in IDLE and at the very end of VFP
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        w_cfg_load  = 1'b0;
        if (r_state == ST_IDLE) begin
            w_h_nxt = '0;
            w_v_nxt = '0;
            if (i_enable) begin
                w_state_nxt = ST_VSYNC;
                w_cfg_load  = 1'b1;
            end
        end else if (!w_line_end) begin
            w_h_nxt = r_h + 1'b1;
        end else begin
            w_h_nxt = '0;
            if (!w_last_line) begin
                w_v_nxt = r_v + 1'b1;
            end else begin
                w_v_nxt = '0;
                case (r_state)
                    ST_VSYNC:  w_state_nxt = ST_VBP;
                    ST_VBP:    w_state_nxt = ST_ACTIVE;
                    ST_ACTIVE: w_state_nxt = ST_VFP;
                    ST_VFP: begin
                        if (i_enable) begin
                            w_state_nxt = ST_VSYNC;
                            w_cfg_load  = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default:   w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    assign o_h          = r_h;
    assign o_v          = r_v;
    assign o_href       = (r_state == ST_ACTIVE) && (r_h < HW'(WIDTH));
    assign o_vsync      = (r_state == ST_VSYNC);
    assign o_frame_done = (r_state == ST_VFP) && w_line_end && w_last_line;
    assign o_cfg_load   = w_cfg_load;

endmodule

// File: rtl/isp_raw_tpg.sv
// rtl/isp_raw_tpg.sv - raw Bayer test-pattern source with grid defect injection
module isp_raw_tpg
    import isp_pkg::*;
#(
    parameter int BITS         = 8,
    parameter int WIDTH        = 1280,
    parameter int HEIGHT       = 960,
    parameter int BAYER        = 0,
    parameter int HBLANK       = 160,
    parameter int VSYNC_LINES  = 2,
    parameter int VBP_LINES    = 8,
    parameter int VFP_LINES    = 8,
    parameter int DEFECT_PITCH = 32
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [1:0]      pattern_sel,
    input  logic [BITS-1:0] level,
    input  logic            defect_en,
    output logic            out_href,
    output logic            out_vsync,
    output logic            out_den,
    output logic [BITS-1:0] out_raw,
    output logic            out_defect,
    output logic            frame_done
);

    localparam int HW   = clog2(WIDTH + HBLANK);
    localparam int VW   = clog2(imax(imax(HEIGHT, VSYNC_LINES), imax(VBP_LINES, VFP_LINES)));
    localparam int PLOG = clog2(DEFECT_PITCH);
    // Coordinates are widened so the ramp slice and grid-parity bit always exist
    localparam int XW   = imax(imax(HW, PLOG + 1), BITS);
    localparam int YW   = imax(imax(VW, PLOG + 1), BITS);

    localparam logic [XW-1:0] X_MASK      = XW'(DEFECT_PITCH - 1);
    localparam logic [XW-1:0] X_HALF      = XW'(DEFECT_PITCH / 2);
    localparam logic [YW-1:0] Y_MASK      = YW'(DEFECT_PITCH - 1);
    localparam logic [YW-1:0] Y_HALF      = YW'(DEFECT_PITCH / 2);
    localparam logic [1:0]    BAYER_ORDER = 2'(BAYER);

    logic [HW-1:0]   w_h;
    logic [VW-1:0]   w_v;
    logic            w_href;
    logic            w_vsync;
    logic            w_frame_done;
    logic            w_cfg_load;
    logic [XW-1:0]   w_x;
    logic [YW-1:0]   w_y;
    logic [1:0]      w_fmt;
    logic [BITS-1:0] w_bayer_pix;
    logic [BITS-1:0] w_pix;
    logic            w_defect_hit;
    logic            w_hot;

    logic [1:0]      r_pattern;
    logic [BITS-1:0] r_level;
    logic            r_defect_en;

    isp_tpg_timing #(
        .WIDTH       (WIDTH),
        .HEIGHT      (HEIGHT),
        .HBLANK      (HBLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .VBP_LINES   (VBP_LINES),
        .VFP_LINES   (VFP_LINES),
        .HW          (HW),
        .VW          (VW)
    ) u_timing (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .i_enable     (enable),
        .o_h          (w_h),
        .o_v          (w_v),
        .o_href       (w_href),
        .o_vsync      (w_vsync),
        .o_frame_done (w_frame_done),
        .o_cfg_load   (w_cfg_load)
    );

    // Frame configuration, captured as each frame enters VSYNC and frozen until the next
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern   <= PAT_FLAT;
            r_level     <= '0;
            r_defect_en <= 1'b0;
        end else if (w_cfg_load) begin
            r_pattern   <= pattern_sel;
            r_level     <= level;
            r_defect_en <= defect_en;
        end
    end

    // During ACTIVE the region line counter is the active line index
    assign w_x = XW'(w_h);
    assign w_y = YW'(w_v);

    // Base pattern value for the current coordinate
    always_comb begin
        w_fmt       = BAYER_ORDER ^ {w_y[0], w_x[0]};
        w_bayer_pix = r_level;
        case (w_fmt)
            FMT_R:   w_bayer_pix = r_level >> 1;
            FMT_B:   w_bayer_pix = r_level >> 2;
            default: w_bayer_pix = r_level;
        endcase
        w_pix = r_level;
        case (r_pattern)
            PAT_FLAT:  w_pix = r_level;
            PAT_BAYER: w_pix = w_bayer_pix;
            PAT_HRAMP: w_pix = w_x[BITS-1:0];
            PAT_VRAMP: w_pix = w_y[BITS-1:0];
            default:   w_pix = r_level;
        endcase
    end

    // Defects sit at the centre of each pitch cell; hot/dead alternates as a checkerboard of cells
    assign w_defect_hit = r_defect_en && w_href
                       && ((w_x & X_MASK) == X_HALF)
                       && ((w_y & Y_MASK) == Y_HALF);
    assign w_hot        = ~(w_x[PLOG] ^ w_y[PLOG]);

    // Output registers; pixel data is forced to zero outside the active window
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_href   <= 1'b0;
            out_vsync  <= 1'b0;
            out_den    <= 1'b0;
            out_raw    <= '0;
            out_defect <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_href   <= w_href;
            out_vsync  <= w_vsync;
            out_den    <= w_href;
            out_defect <= w_defect_hit;
            frame_done <= w_frame_done;
            if (!w_href) begin
                out_raw <= '0;
            end else if (w_defect_hit) begin
                out_raw <= {BITS{w_hot}};
            end else begin
                out_raw <= w_pix;
            end
        end
    end

endmodule

// File: tb/tb_isp_raw_tpg.sv
// tb/tb_isp_raw_tpg.sv - directed self-checking bench for isp_raw_tpg
module tb_isp_raw_tpg;

    localparam int BITS   = 8;
    localparam int WIDTH  = 16;
    localparam int HEIGHT = 12;
    localparam int HBLANK = 4;
    localparam int VSL    = 1;
    localparam int VBP    = 2;
    localparam int VFP    = 2;
    localparam int PITCH  = 8;
    localparam int FRAME  = (VSL + VBP + HEIGHT + VFP) * (WIDTH + HBLANK);

    logic            pclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [1:0]      pattern_sel = 2'd0;
    logic [BITS-1:0] level = '0;
    logic            defect_en = 1'b0;
    logic            out_href;
    logic            out_vsync;
    logic            out_den;
    logic [BITS-1:0] out_raw;
    logic            out_defect;
    logic            frame_done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int       m_vs, m_bursts, m_hrefs, m_defs, m_fd_cyc, m_den_bad, m_blank_bad;
    logic     m_done, m_first_vs;
    logic [7:0] m_img [0:HEIGHT-1][0:WIDTH-1];
    logic       m_dimg [0:HEIGHT-1][0:WIDTH-1];

    int fd1, fd2, fd3, quiet_bad;

    isp_raw_tpg #(
        .BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BAYER(0), .HBLANK(HBLANK),
        .VSYNC_LINES(VSL), .VBP_LINES(VBP), .VFP_LINES(VFP), .DEFECT_PITCH(PITCH)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .level(level), .defect_en(defect_en), .out_href(out_href), .out_vsync(out_vsync),
        .out_den(out_den), .out_raw(out_raw), .out_defect(out_defect), .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected {defect, pixel} for BAYER=0 and pitch 8
    function automatic logic [8:0] exp_pix(input int pat, input logic [7:0] lvl,
                                           input logic dfe, input int x, input int y);
        logic [7:0] p;
        logic [1:0] fmt;
        fmt = {y[0], x[0]};
        case (pat)
            0: p = lvl;
            1: p = (fmt == 2'd0) ? (lvl >> 1) : (fmt == 2'd3) ? (lvl >> 2) : lvl;
            2: p = x[7:0];
            default: p = y[7:0];
        endcase
        if (dfe && (x % 8 == 4) && (y % 8 == 4))
            return {1'b1, ((((x / 8) + (y / 8)) % 2) == 0) ? 8'hFF : 8'h00};
        return {1'b0, p};
    endfunction

    // Watch one frame up to its frame_done; optionally change inputs after a given href burst
    task automatic mon_frame(input int pat, input logic [7:0] lvl, input logic dfe,
                             input int apply_at, input logic [1:0] n_pat,
                             input logic [7:0] n_lvl, input logic n_dfe, input logic n_en);
        int x, y, n;
        logic prev;
        logic [8:0] e;
        x = 0; y = 0; n = 0; prev = 1'b0;
        m_vs = 0; m_bursts = 0; m_hrefs = 0; m_defs = 0; m_den_bad = 0; m_blank_bad = 0;
        m_done = 1'b0; m_first_vs = 1'b0;
        while (!m_done && n < FRAME + 60) begin
            @(negedge pclk);
            n++;
            if (n == 1) m_first_vs = out_vsync;
            if (out_den !== out_href) m_den_bad++;
            if (out_href !== 1'b1 && (out_raw !== 8'h00 || out_defect !== 1'b0)) m_blank_bad++;
            if (out_vsync === 1'b1) begin
                m_vs++; x = 0; y = 0;
            end
            if (out_href === 1'b1) begin
                e = exp_pix(pat, lvl, dfe, x, y);
                chk($sformatf("pixel(%0d,%0d)", x, y), {out_defect, out_raw}, e);
                if (x < WIDTH && y < HEIGHT) begin
                    m_img[y][x]  = out_raw;
                    m_dimg[y][x] = out_defect;
                end
                if (out_defect === 1'b1) m_defs++;
                m_hrefs++;
                x++;
            end else if (prev) begin
                m_bursts++;
                chk("burst_len", x, WIDTH);
                x = 0;
                y++;
                if (m_bursts == apply_at) begin
                    pattern_sel = n_pat;
                    level       = n_lvl;
                    defect_en   = n_dfe;
                    enable      = n_en;
                end
            end
            prev = out_href;
            if (frame_done === 1'b1) begin
                m_done   = 1'b1;
                m_fd_cyc = cyc;
            end
        end
    endtask

    task automatic frame_checks(input string name, input int exp_defs);
        chk({name, "_done"}, m_done, 1);
        chk({name, "_first_vsync"}, m_first_vs, 1);
        chk({name, "_vsync_cycles"}, m_vs, VSL * (WIDTH + HBLANK));
        chk({name, "_bursts"}, m_bursts, HEIGHT);
        chk({name, "_href_cycles"}, m_hrefs, WIDTH * HEIGHT);
        chk({name, "_defects"}, m_defs, exp_defs);
        chk({name, "_den_vs_href"}, m_den_bad, 0);
        chk({name, "_blank_zero"}, m_blank_bad, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge pclk);
        chk("rst_href", out_href, 0);
        chk("rst_vsync", out_vsync, 0);
        chk("rst_den", out_den, 0);
        chk("rst_raw", out_raw, 0);
        chk("rst_defect", out_defect, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;

        // Disabled: 100 quiet cycles
        quiet_bad = 0;
        repeat (100) begin
            @(negedge pclk);
            if ({out_href, out_vsync, out_den, out_defect, frame_done} !== 5'b0 || out_raw !== 8'h00)
                quiet_bad++;
        end
        chk("idle_quiet", quiet_bad, 0);

        // Frame 1: flat 0x40; next frame's config set after the last burst
        pattern_sel = 2'd0; level = 8'h40; defect_en = 1'b0; enable = 1'b1;
        @(negedge pclk);
        chk("vsync_latency", out_vsync, 0);
        mon_frame(0, 8'h40, 1'b0, HEIGHT, 2'd1, 8'h80, 1'b0, 1'b1);
        frame_checks("f1", 0);
        fd1 = m_fd_cyc;

        // Frame 2: Bayer flat 0x80; level changed mid-frame must not take effect
        mon_frame(1, 8'h80, 1'b0, 6, 2'd2, 8'h10, 1'b1, 1'b1);
        frame_checks("f2", 0);
        fd2 = m_fd_cyc;
        chk("period_f1_f2", fd2 - fd1, FRAME);
        chk("bayer_y0_x0", m_img[0][0], 8'h40);
        chk("bayer_y0_x1", m_img[0][1], 8'h80);
        chk("bayer_y1_x0", m_img[1][0], 8'h80);
        chk("bayer_y1_x1", m_img[1][1], 8'h20);
        chk("bayer_y11_x1_after_toggle", m_img[11][1], 8'h20);

        // Frame 3: horizontal ramp with defects; enable dropped mid-ACTIVE
        mon_frame(2, 8'h10, 1'b1, 6, 2'd3, 8'h10, 1'b0, 1'b0);
        frame_checks("f3", 2);
        fd3 = m_fd_cyc;
        chk("period_f2_f3", fd3 - fd2, FRAME);
        chk("hot_4_4_val", m_img[4][4], 8'hFF);
        chk("hot_4_4_flag", m_dimg[4][4], 1);
        chk("dead_12_4_val", m_img[4][12], 8'h00);
        chk("dead_12_4_flag", m_dimg[4][12], 1);
        chk("ramp_5_4", m_img[4][5], 8'h05);
        chk("ramp_4_3_flag", m_dimg[3][4], 0);

        // After the dropped-enable frame the source must stay idle
        quiet_bad = 0;
        repeat (60) begin
            @(negedge pclk);
            if ({out_href, out_vsync, frame_done} !== 3'b0) quiet_bad++;
        end
        chk("idle_after_drop", quiet_bad, 0);

        // Frame 4: vertical ramp restarted from IDLE, then back-to-back start
        enable = 1'b1;
        @(negedge pclk);
        chk("restart_vsync_latency", out_vsync, 0);
        mon_frame(3, 8'h10, 1'b0, -1, 2'd3, 8'h10, 1'b0, 1'b1);
        frame_checks("f4", 0);
        chk("vramp_y7", m_img[7][0], 8'h07);
        @(negedge pclk);
        chk("b2b_vsync", out_vsync, 1);

        // Asynchronous reset in the middle of VSYNC
        rst_n = 1'b0;
        #1;
        chk("async_rst_vsync", out_vsync, 0);
        chk("async_rst_href", out_href, 0);
        chk("async_rst_raw", out_raw, 0);
        @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        chk("post_rst_vsync_latency", out_vsync, 0);
        mon_frame(3, 8'h10, 1'b0, -1, 2'd3, 8'h10, 1'b0, 1'b1);
        frame_checks("f5", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
